// File: rtl/clk_switch_ctrl.sv
// Select sequencer for a glitch-free two-source clock mux: qualifies clk1
// readiness, drives the mux select, holds a guard interval and falls back to clk0.
module clk_switch_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 1000,
    parameter int unsigned TIMEOUT  = 4000,
    parameter int unsigned GUARD    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_sel,
    input  logic clk1_ok,
    output logic clk_sel,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        SWITCH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] qual_cnt_q, qual_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
    logic             req_meta_q, req_s_q;
    logic             ok_meta_q, ok_s_q;
    logic             clk_sel_q, clk_sel_d;
    logic             cur_sel_q, cur_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    // Next-state and output decisions
    always_comb begin
        state_d     = state_q;
        qual_cnt_d  = qual_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        guard_cnt_d = '0;
        clk_sel_d   = clk_sel_q;
        cur_sel_d   = cur_sel_q;
        done_d      = 1'b0;
        fail_d      = fail_q;

        unique case (state_q)
            IDLE: begin
                if (cur_sel_q && !ok_s_q) begin
                    clk_sel_d = 1'b0;
                    fail_d    = 1'b1;
                    state_d   = SWITCH;
                end else if (!req_s_q && cur_sel_q) begin
                    clk_sel_d = 1'b0;
                    state_d   = SWITCH;
                end else if (req_s_q && !cur_sel_q && !fail_q) begin
                    qual_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = QUAL;
                end else if (!req_s_q) begin
                    fail_d = 1'b0;
                end
            end
            QUAL: begin
                if (!req_s_q) begin
                    state_d = IDLE;
                end else if (ok_s_q && (qual_cnt_q == LOCK_LAST)) begin
                    clk_sel_d = 1'b1;
                    state_d   = SWITCH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    qual_cnt_d = ok_s_q ? (qual_cnt_q + CNT_ONE) : '0;
                    tmo_cnt_d  = tmo_cnt_q + CNT_ONE;
                end
            end
            SWITCH: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    cur_sel_d = clk_sel_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters, synchronizers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            qual_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            guard_cnt_q <= '0;
            req_meta_q  <= 1'b0;
            req_s_q     <= 1'b0;
            ok_meta_q   <= 1'b0;
            ok_s_q      <= 1'b0;
            clk_sel_q   <= 1'b0;
            cur_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qual_cnt_q  <= qual_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            req_meta_q  <= req_sel;
            req_s_q     <= req_meta_q;
            ok_meta_q   <= clk1_ok;
            ok_s_q      <= ok_meta_q;
            clk_sel_q   <= clk_sel_d;
            cur_sel_q   <= cur_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign clk_sel = clk_sel_q;
    assign cur_sel = cur_sel_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed cycle positions.
module tb_clk_switch_ctrl;

    localparam int unsigned LOCK  = 16;
    localparam int unsigned TMO   = 64;
    localparam int unsigned GRD   = 8;

    logic clk = 1'b0;
    logic rst;
    logic req_sel;
    logic clk1_ok;
    logic clk_sel, cur_sel, busy, done, fail;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    clk_switch_ctrl #(
        .CNT_W   (16),
        .LOCK_CNT(LOCK),
        .TIMEOUT (TMO),
        .GUARD   (GRD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_sel(req_sel),
        .clk1_ok(clk1_ok),
        .clk_sel(clk_sel),
        .cur_sel(cur_sel),
        .busy   (busy),
        .done   (done),
        .fail   (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: modes with entry timestamps, ok run measured from last low sample
    int  m_mode;
    int  cyc, t_entry, t_low;
    bit  m_sel, m_cur, m_busy, m_done, m_fail;
    bit  r_d1, r_d2, o_d1, o_d2;
    bit  rs, os;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; cyc = 0; t_entry = 0; t_low = 0;
            m_sel = 0; m_cur = 0; m_busy = 0; m_done = 0; m_fail = 0;
            r_d1 = 0; r_d2 = 0; o_d1 = 0; o_d2 = 0;
        end else begin
            rs = r_d2; os = o_d2;
            r_d2 = r_d1; r_d1 = req_sel;
            o_d2 = o_d1; o_d1 = clk1_ok;
            cyc++;
            m_done = 0;
            case (m_mode)
                0: begin
                    if (m_cur && !os) begin
                        m_sel = 0; m_fail = 1; m_mode = 2; t_entry = cyc;
                    end else if (!rs && m_cur) begin
                        m_sel = 0; m_mode = 2; t_entry = cyc;
                    end else if (rs && !m_cur && !m_fail) begin
                        m_mode = 1; t_entry = cyc; t_low = cyc;
                    end else if (!rs) begin
                        m_fail = 0;
                    end
                end
                1: begin
                    if (!os) t_low = cyc;
                    if (!rs) begin
                        m_mode = 0;
                    end else if (os && (cyc - t_low) >= int'(LOCK)) begin
                        m_sel = 1; m_mode = 2; t_entry = cyc;
                    end else if ((cyc - t_entry) >= int'(TMO)) begin
                        m_mode = 0; m_fail = 1;
                    end
                end
                default: begin
                    if ((cyc - t_entry) >= int'(GRD)) begin
                        m_cur = m_sel; m_done = 1; m_mode = 0;
                    end
                end
            endcase
            m_busy = (m_mode != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model clk_sel", int'(clk_sel), int'(m_sel));
            check("model cur_sel", int'(cur_sel), int'(m_cur));
            check("model busy",    int'(busy),    int'(m_busy));
            check("model done",    int'(done),    int'(m_done));
            check("model fail",    int'(fail),    int'(m_fail));
        end
    end

    // Event positions observed during a fixed-length watch window (k = edge index)
    int k_rise, k_fall, k_done, n_done, n_busy, k_fail, k_bfall;

    task automatic watch(input int n);
        logic p_sel, p_fail, p_busy;
        p_sel = clk_sel; p_fail = fail; p_busy = busy;
        k_rise = 0; k_fall = 0; k_done = 0; n_done = 0; n_busy = 0; k_fail = 0; k_bfall = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!p_sel && clk_sel && k_rise == 0) k_rise = k;
            if (p_sel && !clk_sel && k_fall == 0) k_fall = k;
            if (!p_fail && fail && k_fail == 0) k_fail = k;
            if (p_busy && !busy && k_bfall == 0) k_bfall = k;
            if (done) begin
                n_done++;
                if (k_done == 0) k_done = k;
            end
            if (busy) n_busy++;
            p_sel = clk_sel; p_fail = fail; p_busy = busy;
        end
    endtask

    initial begin
        rst = 1'b0; req_sel = 1'b0; clk1_ok = 1'b1;
        repeat (3) @(negedge clk);
        check("reset clk_sel", int'(clk_sel), 0);
        check("reset busy",    int'(busy),    0);
        check("reset fail",    int'(fail),    0);
        rst = 1'b1;
        chk_en = 1'b1;
        watch(4);

        // 0->1 switch with clk1 stable
        req_sel = 1'b1;
        watch(40);
        check("sw01 clk_sel rise", k_rise, 19);
        check("sw01 done",         k_done, 27);
        check("sw01 busy cycles",  n_busy, 24);
        check("sw01 cur_sel",      int'(cur_sel), 1);

        // 1->0 switch
        req_sel = 1'b0;
        watch(20);
        check("sw10 clk_sel fall", k_fall, 3);
        check("sw10 done",         k_done, 11);
        check("sw10 cur_sel",      int'(cur_sel), 0);

        // one-cycle clk1_ok glitch during qualification restarts the lock count
        req_sel = 1'b1;
        watch(12);
        clk1_ok = 1'b0;
        watch(1);
        clk1_ok = 1'b1;
        watch(40);
        check("glitch clk_sel rise", k_rise, 18);
        check("glitch fail",         int'(fail), 0);
        check("glitch cur_sel",      int'(cur_sel), 1);

        // qualification timeout
        req_sel = 1'b0;
        watch(20);
        clk1_ok = 1'b0;
        watch(4);
        req_sel = 1'b1;
        watch(80);
        check("tmo fail rise", k_fail, 67);
        check("tmo done",      n_done, 0);
        check("tmo clk_sel",   int'(clk_sel), 0);
        watch(20);
        check("tmo no requal", n_busy, 0);
        req_sel = 1'b0;
        watch(4);
        check("tmo fail clear", int'(fail), 0);

        // fallback when clk1 readiness is lost
        clk1_ok = 1'b1;
        req_sel = 1'b1;
        watch(40);
        check("fb setup cur_sel", int'(cur_sel), 1);
        clk1_ok = 1'b0;
        watch(20);
        check("fb clk_sel fall", k_fall, 3);
        check("fb fail rise",    k_fail, 3);
        check("fb done",         k_done, 11);
        check("fb cur_sel",      int'(cur_sel), 0);
        req_sel = 1'b0;
        clk1_ok = 1'b1;
        watch(6);
        check("fb fail clear", int'(fail), 0);

        // abort during qualification
        req_sel = 1'b1;
        watch(8);
        req_sel = 1'b0;
        watch(10);
        check("abort busy fall", k_bfall, 3);
        check("abort done",      n_done, 0);
        check("abort fail",      int'(fail), 0);
        check("abort clk_sel",   int'(clk_sel), 0);

        // request reversed mid-SWITCH: completes, then reverse switch next cycle
        req_sel = 1'b1;
        watch(19);
        check("rev clk_sel rise", k_rise, 19);
        req_sel = 1'b0;
        watch(30);
        check("rev first done",   k_done, 8);
        check("rev clk_sel fall", k_fall, 9);
        check("rev done count",   n_done, 2);
        check("rev cur_sel",      int'(cur_sel), 0);

        // asynchronous reset mid-SWITCH toward clk1
        req_sel = 1'b1;
        watch(22);
        check("rst pre clk_sel", int'(clk_sel), 1);
        check("rst pre busy",    int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("rst clk_sel", int'(clk_sel), 0);
        check("rst cur_sel", int'(cur_sel), 0);
        check("rst busy",    int'(busy), 0);
        check("rst fail",    int'(fail), 0);
        req_sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch(5);
        check("post rst idle busy", n_busy, 0);
        check("post rst clk_sel",   int'(clk_sel), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
